// File: rtl/hazard_fwd_if.sv
// Decode-side bundle for the hazard/forwarding unit: instruction fields in,
// stall, operand selects and dm-stage write info out.
interface hazard_fwd_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              valid_id;
  logic [REG_AW-1:0] RA;
  logic [REG_AW-1:0] RB;
  logic [REG_AW-1:0] RW_id;
  logic              wr_en_id;
  logic              is_load_id;
  logic              stall;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic [REG_AW-1:0] RW_dm;
  logic              wr_en_dm;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output valid_id, RA, RB, RW_id, wr_en_id, is_load_id,
    input  stall, mux_sel_A, mux_sel_B, RW_dm, wr_en_dm, stall_count
  );

  modport slave (
    input  valid_id, RA, RB, RW_id, wr_en_id, is_load_id,
    output stall, mux_sel_A, mux_sel_B, RW_dm, wr_en_dm, stall_count
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Load-use stall detection and operand forwarding for a 5-stage pipeline;
// tracks ex/dm/wb destination records and picks the youngest producer.
module hazard_fwd_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_fwd_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] rd;
  } stage_t;

  stage_t            ex_q, dm_q, wb_q;
  stage_t            dec;
  logic [1:0]        sel_a_q, sel_b_q;
  logic [REG_AW-1:0] rw_dm_q;
  logic              wr_en_dm_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              stall_c;

  function automatic logic hit(input stage_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wr && (s.rd == r) && (r != '0);
  endfunction

  // Youngest matching stage wins.
  function automatic logic [1:0] pick(input stage_t ex, input stage_t dm,
                                      input stage_t wb, input logic [REG_AW-1:0] r);
    if (hit(ex, r))      return 2'b01;
    else if (hit(dm, r)) return 2'b10;
    else if (hit(wb, r)) return 2'b11;
    else                 return 2'b00;
  endfunction

  always_comb begin
    dec       = '0;
    dec.valid = bus.valid_id;
    dec.wr    = bus.wr_en_id;
    dec.load  = bus.is_load_id;
    dec.rd    = bus.RW_id;
    stall_c   = bus.valid_id && ex_q.load && (hit(ex_q, bus.RA) || hit(ex_q, bus.RB));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      dm_q       <= '0;
      wb_q       <= '0;
      sel_a_q    <= 2'b00;
      sel_b_q    <= 2'b00;
      rw_dm_q    <= '0;
      wr_en_dm_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wb_q       <= dm_q;
      dm_q       <= ex_q;
      rw_dm_q    <= ex_q.rd;
      wr_en_dm_q <= ex_q.valid & ex_q.wr;
      if (stall_c) begin
        // Load-use: inject a bubble; the held instruction picks dm next cycle.
        ex_q    <= '0;
        sel_a_q <= 2'b00;
        sel_b_q <= 2'b00;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        ex_q    <= dec;
        sel_a_q <= pick(ex_q, dm_q, wb_q, bus.RA);
        sel_b_q <= pick(ex_q, dm_q, wb_q, bus.RB);
      end
    end
  end

  assign bus.stall       = stall_c;
  assign bus.mux_sel_A   = sel_a_q;
  assign bus.mux_sel_B   = sel_b_q;
  assign bus.RW_dm       = rw_dm_q;
  assign bus.wr_en_dm    = wr_en_dm_q;
  assign bus.stall_count = cnt_q;

endmodule
